// File: rtl/ask_pkg.sv
// Shared types and constants for the ASK transmit controller and its tick generator.
package ask_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GUARD = 2'd3
  } state_t;

  localparam int PHASE_W         = 6;
  localparam int SAMPLES_PER_BIT = 64;
  localparam int BIT_CNT_W       = 5;
  localparam int DIV_W           = 8;
endpackage

// File: rtl/ask_tick_gen.sv
// Carrier sample divider and phase counter; wrap marks the last tick of a bit period.
module ask_tick_gen
  import ask_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               run,
  output logic [PHASE_W-1:0] phase,
  output logic               wrap
);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SAMPLES_PER_BIT - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // With DIV=1 the divider never leaves zero, so tick follows run.
  assign tick = run && (div_cnt == DIV_LAST);
  assign wrap = tick && (phase == PHASE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (clear) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (run) begin
      if (tick) begin
        div_cnt <= '0;
        phase   <= phase + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ask_tx_ctrl.sv
// ASK frame transmitter: start bit, NBITS payload bits MSB first, guard period.
module ask_tx_ctrl
  import ask_pkg::*;
#(
  parameter int DIV   = 1,
  parameter int NBITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic [NBITS-1:0]   s_data,
  output logic               s_ready,
  input  logic               abort,
  output logic               din,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               done
);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(NBITS - 1);

  state_t               state_reg, state_next;
  logic [NBITS-1:0]     shift_reg, shift_next;
  logic [NBITS-1:0]     shifted;
  logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic                 din_reg, din_next;
  logic                 wrap, transfer, abort_run, run, tick_clear;

  assign run        = (state_reg != IDLE);
  assign abort_run  = abort && run;
  assign tick_clear = abort_run || !run;
  assign transfer   = s_valid && s_ready;
  assign shifted    = shift_reg << 1;
  assign din        = din_reg;

  ask_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .run   (run),
    .phase (phase),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      din_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      din_reg     <= din_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    din_next     = din_reg;
    if (abort_run) begin
      state_next = IDLE;
      din_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            state_next   = START;
            shift_next   = s_data;
            bit_cnt_next = '0;
            din_next     = 1'b1;
          end
        end
        START: begin
          if (wrap) begin
            state_next   = DATA;
            bit_cnt_next = '0;
            din_next     = shift_reg[NBITS-1];
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_cnt_reg == LAST_BIT) begin
              state_next = GUARD;
              din_next   = 1'b0;
            end else begin
              shift_next   = shifted;
              bit_cnt_next = bit_cnt_reg + 1'b1;
              din_next     = shifted[NBITS-1];
            end
          end
        end
        GUARD: begin
          // A word accepted on the final guard tick chains straight into START.
          if (wrap) begin
            if (transfer) begin
              state_next   = START;
              shift_next   = s_data;
              bit_cnt_next = '0;
              din_next     = 1'b1;
            end else begin
              state_next = IDLE;
              din_next   = 1'b0;
            end
          end
        end
        default: begin
          state_next = IDLE;
          din_next   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    s_ready = (state_reg == IDLE) || ((state_reg == GUARD) && wrap);
    busy    = (state_reg != IDLE);
    done    = (state_reg == GUARD) && wrap && !abort;
  end
endmodule

// File: tb/tb_ask_tx_ctrl.sv
// Directed bench for ask_tx_ctrl: DIV=1 and DIV=3 instances driven from one initial block.
module tb_ask_tx_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       abort = 1'b0;
  logic       s_ready, din, busy, done;
  logic [5:0] phase;

  logic       s_valid3 = 1'b0;
  logic [7:0] s_data3 = 8'h00;
  logic       abort3 = 1'b0;
  logic       s_ready3, din3, busy3, done3;
  logic [5:0] phase3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ask_tx_ctrl #(.DIV(1), .NBITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .abort(abort), .din(din), .phase(phase), .busy(busy), .done(done)
  );

  ask_tx_ctrl #(.DIV(3), .NBITS(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid3), .s_data(s_data3), .s_ready(s_ready3),
    .abort(abort3), .din(din3), .phase(phase3), .busy(busy3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1 of a DIV=1 frame; returns in cycle 641.
  task automatic frame_check(input logic [7:0] d, input logic hold, input logic [7:0] nd);
    int   dones = 0;
    logic exp_din;
    for (int c = 1; c <= 640; c++) begin
      s_valid = hold;
      s_data  = nd;
      @(negedge clk);
      if (c <= 64)       exp_din = 1'b1;
      else if (c <= 576) exp_din = d[7 - (c - 65) / 64];
      else               exp_din = 1'b0;
      check($sformatf("din_c%0d", c), din, exp_din);
      check($sformatf("phase_c%0d", c), phase, (c - 1) % 64);
      check($sformatf("busy_c%0d", c), busy, 1);
      check($sformatf("done_c%0d", c), done, (c == 640));
      check($sformatf("ready_c%0d", c), s_ready, (c == 640));
      if (done) dones++;
      step();
    end
    check("done_count", dones, 1);
    $display("frame data=%02h checked, next_word=%0d", d, hold);
  endtask

  initial begin
    // Reset state
    #2;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_din", din, 0);
    check("rst_phase", phase, 0);
    check("rst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single frame 0xA5 followed by idle
    s_valid = 1'b1; s_data = 8'hA5;
    @(negedge clk);
    check("idle_ready", s_ready, 1);
    check("idle_busy", busy, 0);
    step();
    frame_check(8'hA5, 1'b0, 8'h00);
    @(negedge clk);
    check("post_idle_busy", busy, 0);
    check("post_idle_phase", phase, 0);
    check("post_idle_din", din, 0);
    step();

    // Back-to-back 0xA5 then 0x3C with s_valid held
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    frame_check(8'hA5, 1'b1, 8'h3C);
    frame_check(8'h3C, 1'b0, 8'h00);
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    step();

    // Abort mid-frame at cycle 300
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    for (int c = 1; c < 300; c++) step();
    abort = 1'b1;
    @(negedge clk);
    check("abort300_phase", phase, 43);
    check("abort300_done", done, 0);
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort301_busy", busy, 0);
    check("abort301_din", din, 0);
    check("abort301_phase", phase, 0);
    check("abort301_done", done, 0);
    check("abort301_ready", s_ready, 1);
    $display("abort at cycle 300 checked");
    step();

    // Abort wins over a transfer on the final guard tick
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    for (int c = 1; c < 640; c++) step();
    abort = 1'b1; s_valid = 1'b1; s_data = 8'h3C;
    @(negedge clk);
    check("gabort_ready", s_ready, 1);
    check("gabort_done", done, 0);
    step();
    abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("gabort_busy", busy, 0);
    check("gabort_phase", phase, 0);
    check("gabort_din", din, 0);
    $display("abort on guard end with transfer checked");
    step();

    // Abort in IDLE does not block acceptance; abort in START returns to IDLE
    abort = 1'b1; s_valid = 1'b1; s_data = 8'h81;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("iabort_busy", busy, 1);
    check("iabort_din", din, 1);
    step();
    abort = 1'b0;
    @(negedge clk);
    check("sabort_busy", busy, 0);
    $display("abort in idle and start checked");
    step();

    // Asynchronous reset mid-frame, then a 0x01 frame
    s_valid = 1'b1; s_data = 8'hA5;
    step();
    s_valid = 1'b0;
    for (int c = 1; c < 100; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_din", din, 0);
    check("arst_phase", phase, 0);
    check("arst_done", done, 0);
    step();
    step();
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'h01;
    @(negedge clk);
    check("arst_ready", s_ready, 1);
    step();
    frame_check(8'h01, 1'b0, 8'h00);
    step();

    // DIV=3 frame 0xFF
    s_valid3 = 1'b1; s_data3 = 8'hFF;
    @(negedge clk);
    check("div3_ready", s_ready3, 1);
    step();
    s_valid3 = 1'b0;
    begin
      int dones3 = 0;
      for (int c = 1; c <= 1921; c++) begin
        @(negedge clk);
        check($sformatf("div3_din_c%0d", c), din3, (c <= 1728));
        check($sformatf("div3_phase_c%0d", c), phase3, (c <= 1920) ? ((c - 1) / 3) % 64 : 0);
        check($sformatf("div3_busy_c%0d", c), busy3, (c <= 1920));
        check($sformatf("div3_done_c%0d", c), done3, (c == 1920));
        if (done3) dones3++;
        step();
      end
      check("div3_done_count", dones3, 1);
    end
    $display("frame DIV=3 data=ff checked");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
